// File: rtl/rf_sched_pkg.sv
// Shared types and default sizing for the register-file port scheduler.
package rf_sched_pkg;

    localparam int unsigned DATA_WIDTH_DEF   = 32;
    localparam int unsigned ADDR_WIDTH_DEF   = 5;
    localparam int unsigned NUM_WR_DEF       = 2;
    localparam int unsigned MAX_WR_BURST_DEF = 4;
    localparam int unsigned BURST_W_DEF      = $clog2(MAX_WR_BURST_DEF + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        RD    = 3'd2,
        RDW   = 3'd3,
        RDONE = 3'd4
    } state_t;

    // Counter width able to hold 0..max_burst inclusive.
    function automatic int unsigned burst_width(input int unsigned max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester after ptr (wrapping), one-hot plus index.
module rr_arbiter #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Scan ptr+1, ptr+2, ..., ptr (mod N); the last-granted requester has lowest priority.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = IDX_W'((32'(ptr) + i) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                gnt[cand]   = 1'b1;
                gnt_idx     = cand;
            end
        end
    end

endmodule

// File: rtl/rf_port_scheduler.sv
// Serialises NUM_WR write-back requesters and one read requester onto a single
// register-file port; one operation in flight at a time, completed in grant order.
module rf_port_scheduler
    import rf_sched_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int unsigned NUM_WR       = NUM_WR_DEF,
    parameter int unsigned MAX_WR_BURST = MAX_WR_BURST_DEF,
    parameter bit          ZERO_REG_RO  = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_WR-1:0]              wr_valid,
    output logic [NUM_WR-1:0]              wr_ready,
    input  logic [NUM_WR*ADDR_WIDTH-1:0]   wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0]   wr_data,
    input  logic                           rd_valid,
    output logic                           rd_ready,
    input  logic [ADDR_WIDTH-1:0]          rd_addr1,
    input  logic [ADDR_WIDTH-1:0]          rd_addr2,
    output logic                           rd_done,
    output logic [DATA_WIDTH-1:0]          rd_data1,
    output logic [DATA_WIDTH-1:0]          rd_data2,
    output logic                           rf_read,
    output logic                           rf_write,
    output logic [ADDR_WIDTH-1:0]          rf_addr_r1,
    output logic [ADDR_WIDTH-1:0]          rf_addr_r2,
    output logic [ADDR_WIDTH-1:0]          rf_addr_w,
    output logic [DATA_WIDTH-1:0]          rf_data_w,
    input  logic [DATA_WIDTH-1:0]          rf_data_r1,
    input  logic [DATA_WIDTH-1:0]          rf_data_r2
);

    localparam int unsigned IDX_W   = $clog2(NUM_WR);
    localparam int unsigned BURST_W = burst_width(MAX_WR_BURST);

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      ptr_q;
    logic [BURST_W-1:0]    burst_q;
    logic [NUM_WR-1:0]     arb_gnt;
    logic [IDX_W-1:0]      arb_idx;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  burst_full;
    logic                  wr_accept;
    logic                  rd_accept;

    rr_arbiter #(
        .N     (NUM_WR),
        .IDX_W (IDX_W)
    ) u_arb (
        .req     (wr_valid),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // Payload of the requester the arbiter currently favours.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_WR; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                sel_addr = wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign burst_full = (burst_q == BURST_W'(MAX_WR_BURST));
    assign wr_accept  = |wr_ready;
    assign rd_accept  = rd_ready;

    // Next state and the IDLE-only grant; readiness always implies a valid request.
    always_comb begin
        state_d  = state_q;
        wr_ready = '0;
        rd_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_valid && (!(|wr_valid) || burst_full)) begin
                    rd_ready = 1'b1;
                    state_d  = RD;
                end else if (|wr_valid) begin
                    wr_ready = arb_gnt;
                    state_d  = WR;
                end
            end
            WR:      state_d = IDLE;
            RD:      state_d = RDW;
            RDW:     state_d = RDONE;
            RDONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Write-side capture, round-robin pointer and read-starvation burst counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= IDX_W'(NUM_WR - 1);
            burst_q   <= '0;
            rf_write  <= 1'b0;
            rf_addr_w <= '0;
            rf_data_w <= '0;
        end else begin
            rf_write <= 1'b0;
            if (wr_accept) begin
                rf_addr_w <= sel_addr;
                rf_data_w <= sel_data;
                rf_write  <= !(ZERO_REG_RO && (sel_addr == '0));
                ptr_q     <= arb_idx;
                if (!rd_valid) begin
                    burst_q <= '0;
                end else if (!burst_full) begin
                    burst_q <= burst_q + BURST_W'(1);
                end
            end else if (rd_accept) begin
                burst_q <= '0;
            end
        end
    end

    // Read-side capture: strobe in RD, sample RF outputs in RDW, announce in RDONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_read    <= 1'b0;
            rf_addr_r1 <= '0;
            rf_addr_r2 <= '0;
            rd_done    <= 1'b0;
            rd_data1   <= '0;
            rd_data2   <= '0;
        end else begin
            rf_read <= rd_accept;
            rd_done <= (state_q == RDW);
            if (rd_accept) begin
                rf_addr_r1 <= rd_addr1;
                rf_addr_r2 <= rd_addr2;
            end
            if (state_q == RDW) begin
                rd_data1 <= rf_data_r1;
                rd_data2 <= rf_data_r2;
            end
        end
    end

endmodule

// File: tb/tb_rf_port_scheduler.sv
// Directed and random stimulus for rf_port_scheduler against a transaction-level
// model of the grant rules and an architectural register image.
module tb_rf_port_scheduler;

    localparam int NW   = 2;
    localparam int MAXB = 4;

    typedef struct packed { logic [4:0] a; logic [31:0] d; } wreq_t;
    typedef struct packed { logic [4:0] a1; logic [4:0] a2; } rreq_t;

    logic          clk;
    logic          rst;
    logic [NW-1:0] wr_valid;
    logic [NW-1:0] wr_ready;
    logic [NW*5-1:0]  wr_addr;
    logic [NW*32-1:0] wr_data;
    logic          rd_valid, rd_ready, rd_done;
    logic [4:0]    rd_addr1, rd_addr2;
    logic [31:0]   rd_data1, rd_data2;
    logic          rf_read, rf_write;
    logic [4:0]    rf_addr_r1, rf_addr_r2, rf_addr_w;
    logic [31:0]   rf_data_w, rf_data_r1, rf_data_r2;

    rf_port_scheduler dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_done(rd_done), .rd_data1(rd_data1), .rd_data2(rd_data2),
        .rf_read(rf_read), .rf_write(rf_write),
        .rf_addr_r1(rf_addr_r1), .rf_addr_r2(rf_addr_r2),
        .rf_addr_w(rf_addr_w), .rf_data_w(rf_data_w),
        .rf_data_r1(rf_data_r1), .rf_data_r2(rf_data_r2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rf_init_val(input int i);
        return 32'h5EED_0000 | 32'(i);
    endfunction

    // Register file with synchronous read, preloaded while rf_clear is high.
    logic        rf_clear;
    logic [31:0] mem [32];
    always @(posedge clk) begin
        if (rf_clear) begin
            for (int i = 0; i < 32; i++) mem[i] <= rf_init_val(i);
        end else begin
            if (rf_write) mem[rf_addr_w] <= rf_data_w;
            if (rf_read) begin
                rf_data_r1 <= mem[rf_addr_r1];
                rf_data_r2 <= mem[rf_addr_r2];
            end
        end
    end

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    wreq_t wq0[$];
    wreq_t wq1[$];
    rreq_t rq[$];

    // Reference model state
    logic [31:0] m_regs [32];
    int          m_busy, m_last, m_burst, m_rd_age;
    logic        m_rf_write, m_rf_read;
    logic [4:0]  m_addr_w, m_ar1, m_ar2;
    logic [31:0] m_data_w, m_p1, m_p2, m_rd1, m_rd2;

    // Observation log
    int obs_g[$];
    int n_wr_before_rd, rd_acc_cyc, rd_done_cyc;
    logic seen_rd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_last = NW - 1; m_burst = 0; m_rd_age = 0;
        m_rf_write = 1'b0; m_rf_read = 1'b0;
        m_addr_w = '0; m_ar1 = '0; m_ar2 = '0;
        m_data_w = '0; m_p1 = '0; m_p2 = '0; m_rd1 = '0; m_rd2 = '0;
    endtask

    task automatic clear_log();
        obs_g.delete();
        n_wr_before_rd = 0; rd_acc_cyc = -100; rd_done_cyc = -100; seen_rd = 1'b0;
    endtask

    function automatic logic valid_of(input int c);
        return (c == 0) ? wr_valid[0] : wr_valid[1];
    endfunction

    function automatic logic pending();
        return (wq0.size() > 0) || (wq1.size() > 0) || (rq.size() > 0) ||
               (m_busy > 0) || (m_rd_age > 0);
    endfunction

    task automatic drive_inputs();
        wr_valid = '0; wr_addr = '0; wr_data = '0;
        rd_valid = 1'b0; rd_addr1 = '0; rd_addr2 = '0;
        if (wq0.size() > 0) begin
            wr_valid[0] = 1'b1; wr_addr[4:0] = wq0[0].a; wr_data[31:0] = wq0[0].d;
        end
        if (wq1.size() > 0) begin
            wr_valid[1] = 1'b1; wr_addr[9:5] = wq1[0].a; wr_data[63:32] = wq1[0].d;
        end
        if (rq.size() > 0) begin
            rd_valid = 1'b1; rd_addr1 = rq[0].a1; rd_addr2 = rq[0].a2;
        end
    endtask

    // One clock: drive, check against the model, advance the model across the edge.
    task automatic tick();
        logic [1:0] e_wr;
        logic       acc_w, acc_r;
        int         widx, c;
        wreq_t      w;
        rreq_t      r;
        drive_inputs();
        #2;
        e_wr = '0; acc_w = 1'b0; acc_r = 1'b0; widx = 0;
        if (m_busy == 0) begin
            if (rd_valid && (wr_valid == '0 || m_burst == MAXB)) begin
                acc_r = 1'b1;
            end else if (wr_valid != '0) begin
                for (int k = 1; k <= NW; k++) begin
                    c = (m_last + k) % NW;
                    if (!acc_w && valid_of(c)) begin acc_w = 1'b1; widx = c; end
                end
                e_wr = (widx == 0) ? 2'b01 : 2'b10;
            end
        end
        chk("wr_ready",   32'(wr_ready),   32'(e_wr));
        chk("rd_ready",   32'(rd_ready),   32'(acc_r));
        chk("rf_write",   32'(rf_write),   32'(m_rf_write));
        chk("rf_read",    32'(rf_read),    32'(m_rf_read));
        chk("rf_excl",    32'(rf_read & rf_write), 32'(0));
        chk("rd_done",    32'(rd_done),    32'(m_rd_age == 3));
        chk("rd_data1",   rd_data1,        m_rd1);
        chk("rd_data2",   rd_data2,        m_rd2);
        chk("rf_addr_w",  32'(rf_addr_w),  32'(m_addr_w));
        chk("rf_data_w",  rf_data_w,       m_data_w);
        chk("rf_addr_r1", 32'(rf_addr_r1), 32'(m_ar1));
        chk("rf_addr_r2", 32'(rf_addr_r2), 32'(m_ar2));

        if (wr_ready == 2'b01) obs_g.push_back(0);
        if (wr_ready == 2'b10) obs_g.push_back(1);
        if (|wr_ready && !seen_rd) n_wr_before_rd++;
        if (rd_ready) begin seen_rd = 1'b1; rd_acc_cyc = cyc; end
        if (rd_done) rd_done_cyc = cyc;

        m_rf_write = 1'b0;
        m_rf_read  = 1'b0;
        if (m_rd_age == 3) m_rd_age = 0;
        else if (m_rd_age > 0) m_rd_age++;
        if (m_rd_age == 3) begin m_rd1 = m_p1; m_rd2 = m_p2; end
        if (m_busy > 0) m_busy--;
        if (acc_w) begin
            if (widx == 0) w = wq0.pop_front();
            else           w = wq1.pop_front();
            m_addr_w = w.a; m_data_w = w.d;
            m_rf_write = (w.a != 5'd0);
            if (w.a != 5'd0) m_regs[w.a] = w.d;
            m_last  = widx;
            m_burst = rd_valid ? ((m_burst < MAXB) ? m_burst + 1 : m_burst) : 0;
            m_busy  = 1;
        end else if (acc_r) begin
            r = rq.pop_front();
            m_ar1 = r.a1; m_ar2 = r.a2; m_rf_read = 1'b1;
            m_p1 = m_regs[r.a1]; m_p2 = m_regs[r.a2];
            m_burst = 0; m_busy = 3; m_rd_age = 1;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(input int maxc, input string tag);
        int n = 0;
        while (pending() && n < maxc) begin tick(); n++; end
        chk(tag, 32'(pending()), 32'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wq0.delete(); wq1.delete(); rq.delete();
        wr_valid = '0; rd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rf_clear = 1'b1;
        wr_valid = '0; wr_addr = '0; wr_data = '0;
        rd_valid = 1'b0; rd_addr1 = '0; rd_addr2 = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = rf_init_val(i);
        model_reset();
        clear_log();
        @(posedge clk); @(posedge clk); @(negedge clk);
        rf_clear = 1'b0; rst = 1'b0;

        // Reset state: all outputs quiet
        tick(); tick();

        // Single write then read back
        wq0.push_back('{a: 5'd5, d: 32'hA5A5_A5A5});
        drain(20, "t1_wr_drain");
        rq.push_back('{a1: 5'd5, a2: 5'd5});
        drain(20, "t1_rd_drain");
        chk("t1_rd_data1", rd_data1, 32'hA5A5_A5A5);
        chk("t1_rd_data2", rd_data2, 32'hA5A5_A5A5);

        // Round-robin alternation, four writes in eight cycles
        do_reset(); clear_log();
        for (int i = 0; i < 2; i++) begin
            wq0.push_back('{a: 5'(10 + i), d: 32'h1000 + 32'(i)});
            wq1.push_back('{a: 5'(20 + i), d: 32'h2000 + 32'(i)});
        end
        for (int i = 0; i < 8; i++) tick();
        chk("t2_grants", 32'(obs_g.size()), 32'(4));
        for (int i = 0; i < 4; i++)
            chk("t2_order", 32'((i < obs_g.size()) ? obs_g[i] : -1), 32'(i % 2));
        drain(20, "t2_drain");

        // Read starvation bound
        do_reset(); clear_log();
        for (int i = 0; i < 6; i++) begin
            wq0.push_back('{a: 5'(1 + i), d: $urandom});
            wq1.push_back('{a: 5'(8 + i), d: $urandom});
        end
        rq.push_back('{a1: 5'd1, a2: 5'd8});
        drain(200, "t3_drain");
        chk("t3_wr_before_rd", 32'(n_wr_before_rd), 32'(4));
        chk("t3_done_latency", 32'(rd_done_cyc - rd_acc_cyc), 32'(3));

        // Register zero is read-only
        wq0.push_back('{a: 5'd0, d: 32'hFFFF_FFFF});
        drain(20, "t4_wr_drain");
        rq.push_back('{a1: 5'd0, a2: 5'd0});
        drain(20, "t4_rd_drain");
        chk("t4_zero_reg", rd_data1, rf_init_val(0));

        // Reset while in RD aborts the read
        rq.push_back('{a1: 5'd3, a2: 5'd4});
        tick();
        do_reset(); clear_log();
        for (int i = 0; i < 4; i++) tick();
        chk("t5_no_done", 32'(rd_done_cyc), 32'(-100));
        wq0.push_back('{a: 5'd7, d: 32'h0777_0777});
        wq1.push_back('{a: 5'd9, d: 32'h0999_0999});
        drain(20, "t5_drain");
        chk("t5_first_gnt", 32'((obs_g.size() > 0) ? obs_g[0] : -1), 32'(0));

        // Full sweep of registers 1..31, then paired reads
        for (int i = 1; i < 32; i++) begin
            if (i % 2 == 1) wq0.push_back('{a: 5'(i), d: 32'(i)});
            else            wq1.push_back('{a: 5'(i), d: 32'(i)});
        end
        drain(200, "t6_wr_drain");
        for (int i = 1; i < 32; i++) rq.push_back('{a1: 5'(i), a2: 5'(31 - i)});
        drain(400, "t6_rd_drain");
        chk("t6_last_r1", rd_data1, 32'd31);
        chk("t6_last_r2", rd_data2, rf_init_val(0));

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            if (wq0.size() == 0 && $urandom_range(0, 1) == 1)
                wq0.push_back('{a: 5'($urandom_range(0, 31)), d: $urandom});
            if (wq1.size() == 0 && $urandom_range(0, 1) == 1)
                wq1.push_back('{a: 5'($urandom_range(0, 31)), d: $urandom});
            if (rq.size() == 0 && $urandom_range(0, 2) == 0)
                rq.push_back('{a1: 5'($urandom_range(0, 31)), a2: 5'($urandom_range(0, 31))});
            tick();
        end
        drain(300, "rand_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
